// File: rtl/counter_stream_checker.sv
// Receive-side checker for the up/down counter stimulus streams: locks onto the up-count
// sequence, flags and counts discontinuities. Optional macro COUNTER_STREAM_CHECKER_REVERSE_EN.
module counter_stream_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     counter,
  input  logic [WIDTH-1:0]     counter_reverse,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          sample_count,
  output logic [1:0]           state
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [WIDTH-1:0]     expected_q;
  logic [WIDTH-1:0]     expected_d;
  logic                 have_prev_q;
  logic                 have_prev_d;
  logic [GOOD_W-1:0]    good_run_q;
  logic [GOOD_W-1:0]    good_run_d;
  logic [GOOD_W-1:0]    good_inc;
  logic [BAD_W-1:0]     bad_run_q;
  logic [BAD_W-1:0]     bad_run_d;
  logic [BAD_W-1:0]     bad_inc;
  logic                 err_d;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic [31:0]          sample_count_d;
  logic                 seq_match;
  logic                 sum_bad;
  logic                 beat_bad;

`ifdef COUNTER_STREAM_CHECKER_REVERSE_EN
  // Up and down streams are complements: their sum must wrap to zero.
  assign sum_bad = (WIDTH'(counter + counter_reverse) != '0);
`else
  logic unused_counter_reverse;
  assign unused_counter_reverse = ^counter_reverse;
  assign sum_bad = 1'b0;
`endif

  assign seq_match = have_prev_q && (counter == expected_q);
  assign beat_bad  = !seq_match || sum_bad;
  assign good_inc  = good_run_q + GOOD_W'(1);
  assign bad_inc   = bad_run_q + BAD_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values; every valid beat resyncs expected.
  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    have_prev_d    = have_prev_q;
    good_run_d     = good_run_q;
    bad_run_d      = bad_run_q;
    err_d          = 1'b0;
    err_count_d    = err_count;
    sample_count_d = sample_count;

    if (valid) begin
      sample_count_d = sample_count + 32'd1;
      expected_d     = WIDTH'(counter + WIDTH'(1));
      unique case (state_q)
        SEARCH: begin
          if (!have_prev_q) begin
            have_prev_d = 1'b1;
            good_run_d  = '0;
          end else if (seq_match && !sum_bad) begin
            if (good_inc == GOOD_W'(LOCK_COUNT)) begin
              state_d    = LOCKED;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              good_run_d = good_inc;
            end
          end else begin
            good_run_d = '0;
          end
        end
        LOCKED: begin
          if (beat_bad) begin
            err_d = 1'b1;
            if (err_count != '1) begin
              err_count_d = err_count + ERR_CNT_W'(1);
            end
            if (bad_inc == BAD_W'(UNLOCK_ERRS)) begin
              state_d     = SEARCH;
              good_run_d  = '0;
              bad_run_d   = '0;
              have_prev_d = 1'b1;
            end else begin
              bad_run_d = bad_inc;
            end
          end else begin
            bad_run_d = '0;
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    // Clear only touches the counters, and wins over a same-cycle error.
    if (clear) begin
      err_count_d    = '0;
      sample_count_d = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      expected_q   <= '0;
      have_prev_q  <= 1'b0;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      err          <= 1'b0;
      err_count    <= '0;
      sample_count <= '0;
      locked       <= 1'b0;
    end else begin
      expected_q   <= expected_d;
      have_prev_q  <= have_prev_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      err          <= err_d;
      err_count    <= err_count_d;
      sample_count <= sample_count_d;
      locked       <= (state_d == LOCKED);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Scoreboard bench for counter_stream_checker: each driven beat pushes the expected
// registered outputs, which are popped and compared one edge later.
module tb_counter_stream_checker;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned LOCK_COUNT  = 4;
  localparam int unsigned UNLOCK_ERRS = 2;
  localparam int unsigned ERR_CNT_W   = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 valid;
  logic [WIDTH-1:0]     counter;
  logic [WIDTH-1:0]     counter_reverse;
  logic                 clear;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;
  logic [31:0]          sample_count;
  logic [1:0]           state;

  counter_stream_checker #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid          (valid),
    .counter        (counter),
    .counter_reverse(counter_reverse),
    .clear          (clear),
    .locked         (locked),
    .err            (err),
    .err_count      (err_count),
    .sample_count   (sample_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;
    logic [31:0]          sample_count;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state.
  logic                 m_locked;
  logic                 m_have_prev;
  logic [WIDTH-1:0]     m_expected;
  int                   m_good;
  int                   m_bad;
  logic                 m_err;
  logic [ERR_CNT_W-1:0] m_err_count;
  logic [31:0]          m_sample_count;
  logic [WIDTH-1:0]     next_cnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic c,
                            input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] rev);
    logic             match;
    logic             bad_sum;
    logic [WIDTH-1:0] sum;
    if (!r) begin
      m_locked = 0; m_have_prev = 0; m_expected = '0; m_good = 0; m_bad = 0;
      m_err = 0; m_err_count = '0; m_sample_count = '0;
      return;
    end
    m_err = 0;
    if (v) begin
      sum = cnt + rev;
`ifdef COUNTER_STREAM_CHECKER_REVERSE_EN
      bad_sum = (sum != '0);
`else
      bad_sum = 1'b0;
`endif
      match = m_have_prev && (cnt == m_expected);
      m_sample_count = m_sample_count + 32'd1;
      if (!m_locked) begin
        if (!m_have_prev) begin
          m_have_prev = 1; m_good = 0;
        end else if (match && !bad_sum) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin m_locked = 1; m_good = 0; m_bad = 0; end
        end else begin
          m_good = 0;
        end
      end else if (!match || bad_sum) begin
        m_err = 1;
        if (m_err_count != '1) m_err_count = m_err_count + 1'b1;
        m_bad++;
        if (m_bad == UNLOCK_ERRS) begin m_locked = 0; m_good = 0; m_bad = 0; end
      end else begin
        m_bad = 0;
      end
      m_expected = cnt + 1;
    end
    if (c) begin m_err_count = '0; m_sample_count = '0; end
  endtask

  task automatic beat_full(input logic r, input logic v, input logic c,
                           input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] rev);
    exp_t e;
    @(negedge clk);
    reset = r; valid = v; clear = c; counter = cnt; counter_reverse = rev;
    model_step(r, v, c, cnt, rev);
    e.locked = m_locked; e.err = m_err; e.err_count = m_err_count; e.sample_count = m_sample_count;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("locked", 64'(locked), 64'(e.locked));
      check("err", 64'(err), 64'(e.err));
      check("err_count", 64'(err_count), 64'(e.err_count));
      check("sample_count", 64'(sample_count), 64'(e.sample_count));
      check("state", 64'(state), 64'({1'b0, e.locked}));
    end
    next_cnt = cnt + 1;
  endtask

  // Valid beat with a complementary reverse stream.
  task automatic beat(input logic [WIDTH-1:0] cnt, input logic c = 1'b0);
    beat_full(1'b1, 1'b1, c, cnt, WIDTH'(-cnt));
  endtask

  task automatic idle(input logic c = 1'b0);
    beat_full(1'b1, 1'b0, c, 32'hDEAD_BEEF, 32'h1234_5678);
  endtask

  initial begin
    reset = 0; valid = 0; clear = 0; counter = '0; counter_reverse = '0; next_cnt = '0;
    model_step(1'b0, 1'b0, 1'b0, '0, '0);

    // Reset state.
    beat_full(1'b0, 1'b0, 1'b0, '0, '0);
    beat_full(1'b0, 1'b1, 1'b0, 32'd7, '0);

    // Acquire lock on 0..4.
    for (int i = 0; i <= 4; i++) beat(WIDTH'(i));
    check("lock_at_4", 64'(locked), 64'd1);
    check("samples_at_lock", 64'(sample_count), 64'd5);
    check("no_err_at_lock", 64'(err_count), 64'd0);

    // Single jump while locked: one error, stays locked.
    for (int i = 5; i <= 12; i++) beat(WIDTH'(i));
    beat(32'd20);
    check("jump_err_pulse", 64'(err), 64'd1);
    beat(32'd21);
    check("jump_err_single", 64'(err), 64'd0);
    check("jump_err_count", 64'(err_count), 64'd1);
    check("jump_still_locked", 64'(locked), 64'd1);

    // Two consecutive errors unlock; relock from resynced sample.
    beat(32'd22);
    beat(32'd30);
    beat(32'd50);
    check("unlock_state", 64'(state), 64'd0);
    check("unlock_err_count", 64'(err_count), 64'd3);
    for (int i = 51; i <= 55; i++) beat(WIDTH'(i));
    check("relock", 64'(locked), 64'd1);

    // Wrap with valid gaps after a fresh reset.
    beat_full(1'b0, 1'b0, 1'b0, '0, '0);
    beat(32'hFFFF_FFFE); idle();
    beat(32'hFFFF_FFFF); idle();
    beat(32'h0); idle();
    beat(32'h1); idle();
    beat(32'h2);
    check("wrap_lock", 64'(locked), 64'd1);
    check("wrap_no_err", 64'(err_count), 64'd0);

    // Saturate the error counter with alternating bad/good beats.
    for (int i = 0; i < 20; i++) begin
      beat(next_cnt + 32'd100);
      beat(next_cnt);
    end
    check("err_sat", 64'(err_count), 64'd15);

    // Clear collides with an error: pulse present, count zeroed.
    beat(next_cnt + 32'd9, 1'b1);
    check("clear_err_pulse", 64'(err), 64'd1);
    check("clear_err_count", 64'(err_count), 64'd0);
    check("clear_keeps_fsm", 64'(locked), 64'd1);
    beat(next_cnt);

    // Reset while locked with a valid beat present.
    beat_full(1'b0, 1'b1, 1'b0, next_cnt, WIDTH'(-next_cnt));
    check("reset_mid_lock", 64'({locked, err, err_count, sample_count, state}), 64'd0);

    // Reverse-sum check while locked.
    for (int i = 95; i <= 99; i++) beat(WIDTH'(i));
    beat_full(1'b1, 1'b1, 1'b0, 32'd100, 32'hFFFF_FF9B);
`ifdef COUNTER_STREAM_CHECKER_REVERSE_EN
    check("rev_err", 64'(err), 64'd1);
`else
    check("rev_no_err", 64'(err), 64'd0);
`endif
    beat(32'd101);

    // Randomised stream with occasional jumps, gaps and clears.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 15) == 0);
      else if ($urandom_range(0, 9) == 0) beat($urandom, $urandom_range(0, 15) == 0);
      else beat(next_cnt, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
